// File: rtl/md5_link_pkg.sv
// Shared definitions for the MD5 brute-forcer host command link:
// deframer state encoding, word geometry and the command opcodes.
package md5_link_pkg;

  typedef enum logic [1:0] {
    ASSEMBLE  = 2'd0,
    STROBE_HI = 2'd1,
    STROBE_LO = 2'd2,
    TX        = 2'd3
  } link_state_e;

  localparam int BYTES_PER_WORD = 4;

  // Opcodes understood by the brute-forcer controller
  localparam logic [31:0] OP_RESET      = 32'h5230_0000;
  localparam logic [31:0] OP_START      = 32'h5230_0001;
  localparam logic [31:0] OP_SET_A      = 32'h5230_1000;
  localparam logic [31:0] OP_SET_B      = 32'h5230_1001;
  localparam logic [31:0] OP_SET_C      = 32'h5230_1002;
  localparam logic [31:0] OP_SET_D      = 32'h5230_1003;
  localparam logic [31:0] OP_SET_RANGE  = 32'h5230_2000;
  localparam logic [31:0] OP_GET_CNT_LO = 32'h5230_3000;
  localparam logic [31:0] OP_GET_CNT_HI = 32'h5230_3001;

endpackage

// File: rtl/md5_resp_serializer.sv
// Returns one 32-bit result word to the host as 4 bytes, MSB first.
// Handshake: a byte transfers on a cycle where tx_valid && tx_ready are both high.
module md5_resp_serializer
  import md5_link_pkg::*;
(
  input  logic        clk,
  input  logic        reset2,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] sh;
  logic [1:0]  idx;

  assign tx_data = sh[31:24];
  assign done    = tx_valid && tx_ready && (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      sh       <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      sh       <= word;
      idx      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      sh  <= {sh[23:0], 8'h00};
      idx <= idx + 2'd1;
      if (done) tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/md5_cmd_deframer.sv
// Host byte stream -> 32-bit command word with a held strobe, then returns
// the downstream result word as 4 bytes. Partial words time out to keep alignment.
module md5_cmd_deframer
  import md5_link_pkg::*;
#(
  parameter int STROBE_CYCLES  = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic        clk,
  input  logic        reset2,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] cmd_data,
  output logic        cmd_strobe,
  input  logic [31:0] resp_word,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [7:0]  frame_err_cnt,
  output logic        busy
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  link_state_e     state;
  logic [1:0]      idx;
  logic [23:0]     hold;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_next;
  logic [7:0]      ph;
  logic            accept;
  logic            resp_load;
  logic            tx_done;

  assign accept    = rx_valid && rx_ready;
  assign to_next   = to_cnt + 1'b1;
  // resp_word settles after the strobe rise; sample it once, at the end of the gap
  assign resp_load = (state == STROBE_LO) && (ph == 8'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      state         <= ASSEMBLE;
      idx           <= '0;
      hold          <= '0;
      to_cnt        <= '0;
      ph            <= '0;
      rx_ready      <= 1'b1;
      cmd_data      <= '0;
      cmd_strobe    <= 1'b0;
      frame_err_cnt <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        ASSEMBLE: begin
          if (accept) begin
            to_cnt <= '0;
            idx    <= idx + 2'd1;
            case (idx)
              2'd0: hold[23:16] <= rx_data;
              2'd1: hold[15:8]  <= rx_data;
              2'd2: hold[7:0]   <= rx_data;
              default: begin
                cmd_data   <= {hold, rx_data};
                cmd_strobe <= 1'b1;
                rx_ready   <= 1'b0;
                busy       <= 1'b1;
                ph         <= '0;
                state      <= STROBE_HI;
              end
            endcase
          end else if (idx != 2'd0) begin
            if (to_next == TO_LIMIT) begin
              idx    <= '0;
              to_cnt <= '0;
              if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
            end else begin
              to_cnt <= to_next;
            end
          end
        end
        STROBE_HI: begin
          if (ph == 8'(STROBE_CYCLES - 1)) begin
            cmd_strobe <= 1'b0;
            ph         <= '0;
            state      <= STROBE_LO;
          end else begin
            ph <= ph + 8'd1;
          end
        end
        STROBE_LO: begin
          if (resp_load) begin
            ph    <= '0;
            state <= TX;
          end else begin
            ph <= ph + 8'd1;
          end
        end
        TX: begin
          if (tx_done) begin
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ASSEMBLE;
          end
        end
        default: state <= ASSEMBLE;
      endcase
    end
  end

  md5_resp_serializer u_ser (
    .clk      (clk),
    .reset2   (reset2),
    .load     (resp_load),
    .word     (resp_word),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_md5_cmd_deframer.sv
// Bench for md5_cmd_deframer: directed vector table, timeout/reset/saturation
// sequences and random traffic, all checked against a cycle-offset reference model.
module tb_md5_cmd_deframer;
  import md5_link_pkg::*;

  localparam int S  = 4;
  localparam int G  = 2;
  localparam int T  = 20;
  localparam int TW = 5;

  logic        clk = 1'b0;
  logic        reset2;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] cmd_data;
  logic        cmd_strobe;
  logic [31:0] resp_word;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [7:0]  frame_err_cnt;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  md5_cmd_deframer #(
    .STROBE_CYCLES (S),
    .GAP_CYCLES    (G),
    .TIMEOUT_CYCLES(T),
    .TO_W          (TW)
  ) dut (
    .clk          (clk),
    .reset2       (reset2),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .cmd_data     (cmd_data),
    .cmd_strobe   (cmd_strobe),
    .resp_word    (resp_word),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .frame_err_cnt(frame_err_cnt),
    .busy         (busy)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (negedge, cycle offsets) ----------------
  int          n = 0;
  int          w = 0;
  int          last_acc = 0;
  bit          active = 0;
  int          exp_err = 0;
  logic [31:0] word;
  logic [7:0]  part_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          strobe_rises = 0;
  logic        prev_strobe = 1'b0;
  logic [31:0] last_cmd = '0;

  always @(negedge clk) begin
    bit rx_acc;
    bit exp_strobe;
    bit exp_txv;
    n++;
    if (reset2) begin
      part_q.delete();
      exp_q.delete();
      got_q.delete();
      active      = 0;
      exp_err     = 0;
      prev_strobe = 1'b0;
    end else begin
      rx_acc     = rx_valid && !active;
      exp_strobe = active && (n > w) && (n <= w + S);
      exp_txv    = active && (n > w + S + G);
      check("frame_err_cnt", frame_err_cnt, exp_err);
      check("rx_ready", rx_ready, !active);
      check("busy", busy, active);
      check("cmd_strobe", cmd_strobe, exp_strobe);
      check("tx_valid", tx_valid, exp_txv);
      if (active && n > w) check("cmd_data", cmd_data, word);
      if (cmd_strobe && !prev_strobe) begin
        strobe_rises++;
        last_cmd = cmd_data;
      end
      prev_strobe = cmd_strobe;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (active && n == w + S + G)
        for (int k = 0; k < 4; k++) exp_q.push_back(resp_word[31-8*k -: 8]);
      if (exp_txv && exp_q.size() != 0) begin
        check("tx_data", tx_data, exp_q[0]);
        if (tx_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) active = 0;
        end
      end
      if (rx_acc) begin
        part_q.push_back(rx_data);
        last_acc = n;
        if (part_q.size() == 4) begin
          word   = {part_q[0], part_q[1], part_q[2], part_q[3]};
          w      = n;
          active = 1;
          part_q.delete();
        end
      end else if (part_q.size() != 0 && n - last_acc == T) begin
        part_q.delete();
        if (exp_err < 255) exp_err++;
      end
    end
  end

  // ---------------- tx_ready driver ----------------
  int         tx_mode = 0;
  int         tp = 0;
  logic [3:0] pat = 4'b1001;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = pat[tp];
          tp = (tp + 1) % 4;
        end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int k = 0; k < 4; k++) send_byte(v[31-8*k -: 8]);
  endtask

  task automatic wait_resp(output logic [31:0] got);
    got = 'x;
    for (int i = 0; i < 400 && got_q.size() < 4; i++) tick();
    check("resp_byte_count", got_q.size(), 4);
    if (got_q.size() >= 4) got = {got_q[0], got_q[1], got_q[2], got_q[3]};
    got_q.delete();
    tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset2 = 1'b1;
    #1;
    check("rst_cmd_strobe", cmd_strobe, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_frame_err", frame_err_cnt, 0);
    @(posedge clk);
    #1;
    reset2 = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] cmd;
    logic [31:0] resp;
    int          mode;
    logic [31:0] exp_cmd;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] got;
    logic [31:0] r;
    int          rises0;

    reset2 = 1'b1; rx_valid = 1'b0; rx_data = '0; resp_word = '0;
    repeat (3) tick();
    check("reset_rx_ready", rx_ready, 1);
    check("reset_cmd_data", cmd_data, 0);
    check("reset_cmd_strobe", cmd_strobe, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_frame_err", frame_err_cnt, 0);
    check("reset_busy", busy, 0);
    reset2 = 1'b0;
    tick();

    vecs[0] = '{OP_START,     32'hDEADBEEF, 0, 32'h52300001, 32'hDEADBEEF};
    vecs[1] = '{OP_SET_A,     32'hDEADBEEF, 1, 32'h52301000, 32'hDEADBEEF};
    vecs[2] = '{32'h0,        32'h00000000, 0, 32'h00000000, 32'h00000000};
    vecs[3] = '{OP_SET_D,     32'hFFFFFFFF, 2, 32'h52301003, 32'hFFFFFFFF};
    vecs[4] = '{OP_SET_RANGE, 32'hA5C30F96, 1, 32'h52302000, 32'hA5C30F96};

    for (int i = 0; i < 5; i++) begin
      tx_mode   = vecs[i].mode;
      tp        = 0;
      resp_word = vecs[i].resp;
      rises0    = strobe_rises;
      send_word(vecs[i].cmd);
      wait_resp(got);
      check($sformatf("vec%0d_cmd", i), last_cmd, vecs[i].exp_cmd);
      check($sformatf("vec%0d_resp", i), got, vecs[i].exp_resp);
      check($sformatf("vec%0d_strobes", i), strobe_rises - rises0, 1);
    end

    // partial word expires after T idle cycles; next 4 bytes form a fresh word
    tx_mode = 0;
    resp_word = 32'h13579BDF;
    rises0 = strobe_rises;
    send_byte(8'h52); send_byte(8'h30);
    repeat (T) tick();
    check("timeout_err_cnt", frame_err_cnt, 1);
    send_word(OP_GET_CNT_LO);
    wait_resp(got);
    check("timeout_cmd", last_cmd, 32'h52303000);
    check("timeout_strobes", strobe_rises - rises0, 1);
    check("timeout_resp", got, 32'h13579BDF);

    // byte arriving on the expiry cycle wins
    rises0 = strobe_rises;
    send_byte(8'h52);
    repeat (T - 1) tick();
    send_byte(8'h30); send_byte(8'h30); send_byte(8'h01);
    wait_resp(got);
    check("expiry_win_err_cnt", frame_err_cnt, 1);
    check("expiry_win_cmd", last_cmd, 32'h52303001);
    check("expiry_win_strobes", strobe_rises - rises0, 1);

    // reset during STROBE_HI, then a NoOp word
    resp_word = 32'hCAFEF00D;
    send_word(OP_SET_B);
    #2;
    reset2 = 1'b1;
    #1;
    check("midrst_cmd_strobe", cmd_strobe, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_cmd_data", cmd_data, 0);
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    tick();
    rises0 = strobe_rises;
    send_word(32'h0);
    wait_resp(got);
    check("midrst_noop_cmd", last_cmd, 32'h0);
    check("midrst_noop_strobes", strobe_rises - rises0, 1);
    check("midrst_noop_resp", got, 32'hCAFEF00D);

    // random traffic with inter-byte gaps below the timeout
    tx_mode = 2;
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      resp_word = $urandom;
      rises0 = strobe_rises;
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        send_byte(r[31-8*k -: 8]);
      end
      wait_resp(got);
      check("rand_cmd", last_cmd, r);
      check("rand_resp", got, resp_word);
      check("rand_strobes", strobe_rises - rises0, 1);
    end

    // 256 timeouts saturate the error counter
    tx_mode = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'($urandom));
      repeat (T) tick();
    end
    check("sat_err_cnt", frame_err_cnt, 255);
    check("sat_rx_ready", rx_ready, 1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_assert++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md5_cmd_deframer.md
Name: md5_cmd_deframer

Overview:
Upstream command-link stage for the MD5 brute-forcer. It takes the byte stream from the host MCU link, assembles big-endian 32-bit command words, and presents each word with a clean, held strobe. That strobe is the hasReceived/dataIn pair of the brute-forcer, which clocks its controller on the strobe's rising edge. After each word the block samples the brute-forcer's result word (dataOut) and returns it to the host as 4 bytes. Inter-byte timeout recovery keeps host and FPGA word-aligned.

Parameters:
STROBE_CYCLES, 4, cycles cmd_strobe is held high (min 2)
GAP_CYCLES, 2, cycles cmd_strobe is held low after the high phase, before the response is sampled (min 2)
TIMEOUT_CYCLES, 100000, idle clk cycles allowed between bytes of a partial word
TO_W, 17, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset2  in  1  asynchronous, active-high reset
rx_valid  in  1  host byte available
rx_data  in  8  host byte
rx_ready  out  1  deframer accepts byte this cycle
cmd_data  out  32  assembled command word (to dataIn)
cmd_strobe  out  1  word-valid strobe (to hasReceived)
resp_word  in  32  result word from downstream (dataOut)
tx_valid  out  1  response byte valid
tx_data  out  8  response byte
tx_ready  in  1  host link accepts response byte
frame_err_cnt  out  8  saturating count of discarded partial words
busy  out  1  high in any state other than ASSEMBLE

Behaviour:
- Reset (async, reset2=1):
  - state=ASSEMBLE, byte index=0.
  - rx_ready=1; cmd_data=0; cmd_strobe=0; tx_valid=0; tx_data=0; frame_err_cnt=0; busy=0; timeout counter=0.
  - Reset mid-operation aborts any partial word, strobe or response immediately; no further bytes are emitted.
- ASSEMBLE:
  - rx_ready=1. A byte is accepted when rx_valid&&rx_ready. Byte k (k=0..3) goes to bits [31-8k -: 8], so the first byte is the MSB.
  - The timeout counter clears on each accepted byte and increments each cycle while index!=0 and no byte is accepted.
  - Counter reaches TIMEOUT_CYCLES: index->0, partial word discarded, frame_err_cnt+=1 (saturates at 255). A byte accepted on the expiry cycle wins: no error, counter clears.
  - Fourth byte accepted: cmd_data loads the full word on the next edge, in the same cycle cmd_strobe goes 1 -> STROBE_HI.
  - cmd_data changes only on that load and is otherwise held stable across STROBE_HI/STROBE_LO, giving setup margin on the strobe edge.
- STROBE_HI: rx_ready=0; cmd_strobe=1 for exactly STROBE_CYCLES cycles -> STROBE_LO.
- STROBE_LO: cmd_strobe=0 for GAP_CYCLES cycles. On the last cycle resp_word is captured into the shift register -> TX.
  - resp_word is quasi-static: it is updated on the strobe rising edge and only read after the GAP, so a single sample with no synchronizer is decided.
- TX:
  - tx_valid=1, tx_data=current byte, MSB byte first. The byte advances only on tx_valid&&tx_ready; tx_valid stays high between bytes.
  - After the 4th handshake: tx_valid=0 -> ASSEMBLE, index=0.
  - tx_ready held low stalls indefinitely; no timeout in TX.
- rx_ready=0 in all states except ASSEMBLE; rx bytes are back-pressured, never dropped.
- Every accepted word yields exactly one strobe and one 4-byte response, including NoOp (0x00000000).
- Latency: 4th byte accept -> cmd_strobe rise = 1 cycle. The first tx_valid rises one cycle after the resp capture cycle (end of STROBE_LO); this delay is fixed in cycles from the strobe rise and independent of tx_ready.
- Timeout counter width is TO_W; the compare is ==TIMEOUT_CYCLES.

Decomposition:
- Package md5_link_pkg:
  - state enum {ASSEMBLE, STROBE_HI, STROBE_LO, TX}
  - BYTES_PER_WORD=4
  - command opcode constants shared with the brute-forcer: 0x52300000 reset, 0x52300001 start, 0x52301000-3 set expected A-D, 0x52302000 set range, 0x52303000/1 get count low/high.
- One sub-module, md5_resp_serializer: loads 32 bits, emits 4 bytes MSB-first over valid/ready, and signals done.

Test Plan:
- Bytes 52 30 00 01 back-to-back -> cmd_data=0x52300001; cmd_strobe high exactly 4 cycles, rising 1 cycle after the 4th accept; rx_ready=0 throughout.
- Same as above with resp_word=0xDEADBEEF, tx_ready=1 -> tx bytes DE AD BE EF on consecutive cycles, then rx_ready=1.
- Bytes 52 30, then 100000 idle cycles, then 52 30 30 00 -> frame_err_cnt=1; a single strobe occurs, with cmd_data=0x52303000.
- Response with tx_ready toggled 1,0,0,1,... -> each byte holds stable while stalled; order DE AD BE EF preserved; no extra bytes.
- reset2 pulsed during STROBE_HI -> cmd_strobe=0 and tx_valid=0 asynchronously; the next 4 bytes 00 00 00 00 yield cmd_data=0 and one strobe.
- 256 timed-out partial words -> frame_err_cnt saturates at 255.
